// File: rtl/vec_to_phase.sv
// vec_to_phase: iterative CORDIC (vectoring mode) that turns a signed
// (dx, dy) vector into a PHASE_W-bit phase, 2^PHASE_W steps per turn.
// One micro-rotation per clock; done pulses ITER+1 cycles after start.
// Optional: define VEC_TO_PHASE_MAG_EN to add the gain-compensated
// magnitude output mag (one extra multiplier, same latency).
module vec_to_phase #(
    parameter int IN_W    = 18,
    parameter int PHASE_W = 10,
    parameter int ITER    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [IN_W-1:0] dx,
    input  logic signed [IN_W-1:0] dy,
    output logic                   busy,
    output logic                   done,
    output logic [PHASE_W-1:0]     phase
`ifdef VEC_TO_PHASE_MAG_EN
    ,
    output logic [IN_W:0]          mag
`endif
);

    localparam int          WW    = IN_W + 2;     // working width: negation + CORDIC gain
    localparam int          CW    = 4;            // iteration counter width (ITER <= 14)
    localparam int          SH    = 16 - PHASE_W;
    localparam logic [15:0] RND16 = 16'(1 << (15 - PHASE_W));

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_FIN} state_t;

    state_t               r_state;
    state_t               w_next;
    logic signed [WW-1:0] r_x;
    logic signed [WW-1:0] r_y;
    logic [15:0]          r_z;
    logic [CW-1:0]        r_i;
    logic                 r_zero;
    logic                 r_done;
    logic [PHASE_W-1:0]   r_phase;

    logic                 w_load;
    logic                 w_last;
    logic signed [WW-1:0] w_dx_ext;
    logic signed [WW-1:0] w_dy_ext;
    logic signed [WW-1:0] w_xs;
    logic signed [WW-1:0] w_ys;
    logic signed [WW-1:0] w_x_rot;
    logic signed [WW-1:0] w_y_rot;
    logic [15:0]          w_z_rot;
    logic [15:0]          w_atan;

    // atan(2^-i) in 16-bit binary angle units (65536 per turn)
    function automatic logic [15:0] f_atan(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            4'd12:   return 16'd3;
            4'd13:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_ROT;
            S_ROT:   if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs and strobes
    always_comb begin
        busy   = (r_state != S_IDLE);
        w_load = (r_state == S_IDLE) && start;
        w_last = (r_i == CW'(ITER - 1));
    end

    // one micro-rotation from the pre-update x/y, direction from sign of y
    always_comb begin
        w_dx_ext = $signed({{2{dx[IN_W-1]}}, dx});
        w_dy_ext = $signed({{2{dy[IN_W-1]}}, dy});
        w_xs     = r_x >>> r_i;
        w_ys     = r_y >>> r_i;
        w_atan   = f_atan(r_i);
        if (r_y[WW-1]) begin
            w_x_rot = r_x - w_ys;
            w_y_rot = r_y + w_xs;
            w_z_rot = r_z - w_atan;
        end else begin
            w_x_rot = r_x + w_ys;
            w_y_rot = r_y - w_xs;
            w_z_rot = r_z + w_atan;
        end
    end

    // datapath: pre-rotate on load, iterate in ROT, round phase in FIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= '0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (w_load) begin
                // left half-plane: rotate by a half turn so x starts non-negative
                if (dx[IN_W-1]) begin
                    r_x <= -w_dx_ext;
                    r_y <= -w_dy_ext;
                    r_z <= 16'd32768;
                end else begin
                    r_x <= w_dx_ext;
                    r_y <= w_dy_ext;
                    r_z <= '0;
                end
                r_i    <= '0;
                r_zero <= (dx == '0) && (dy == '0);
            end else if (r_state == S_ROT) begin
                r_x <= w_x_rot;
                r_y <= w_y_rot;
                r_z <= w_z_rot;
                r_i <= r_i + CW'(1);
            end else if (r_state == S_FIN) begin
                // a zero vector keeps y at 0, which counts as non-negative, so
                // z would climb through every table angle; force phase 0 instead
                r_phase <= r_zero ? '0 : PHASE_W'((r_z + RND16) >> SH);
            end
        end
    end

    assign done  = r_done;
    assign phase = r_phase;

`ifdef VEC_TO_PHASE_MAG_EN
    localparam int MW = IN_W + 1;
    localparam int PW = WW + 15;

    logic [MW-1:0] r_mag;

    // gain-compensated magnitude (x_final * 19899 / 2^15), captured with phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag <= '0;
        end else if (r_state == S_FIN) begin
            r_mag <= MW'((PW'($unsigned(r_x)) * PW'(19899)) >> 15);
        end
    end

    assign mag = r_mag;
`endif

endmodule
